// File: rtl/reg_alu_sequencer.sv
// Four-phase register-file ALU sequencer: accept an op, read two registers,
// compute, then write the result back. One operation in flight at a time.
module reg_alu_sequencer #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    opcode,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic [AW-1:0] rf_addr1,
  output logic [AW-1:0] rf_addr2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic          rf_write,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [15:0]   op_count
);

  // Handshake: an operation transfers on a rising edge where op_valid and
  // op_ready are both 1; op_ready is high only in IDLE and never during reset.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      opcode_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   rf_addr1_q, rf_addr2_q;
  logic [DW-1:0]   op1_q, op2_q;
  logic [DW-1:0]   result_q, alu_d;
  logic [15:0]     op_count_q;
  logic            accept;

  assign accept = (state_q == S_IDLE) && op_valid && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) state_d = S_IDLE;
  end

  // Add/sub wrap at DW bits; no carry is kept.
  always_comb begin
    alu_d = '0;
    case (opcode_q)
      2'b00:   alu_d = op1_q + op2_q;
      2'b01:   alu_d = op1_q - op2_q;
      2'b10:   alu_d = op1_q & op2_q;
      default: alu_d = op1_q | op2_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      rd_q       <= '0;
      rf_addr1_q <= '0;
      rf_addr2_q <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Source addresses are latched straight into the read-address
        // registers so they hold their value after READ.
        opcode_q   <= opcode;
        rd_q       <= rd;
        rf_addr1_q <= rs1;
        rf_addr2_q <= rs2;
      end
      if (state_q == S_READ) begin
        op1_q <= rf_data1;
        op2_q <= rf_data2;
      end
      if (state_q == S_EXEC) result_q <= alu_d;
      if (state_q == S_WRITE) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_ready = (state_q == S_IDLE) && !rst;
  assign rf_addr1 = rf_addr1_q;
  assign rf_addr2 = rf_addr2_q;
  assign rf_write = (state_q == S_WRITE);
  assign done     = (state_q == S_WRITE);
  assign rf_waddr = rd_q;
  assign rf_wdata = result_q;
  assign result   = result_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Randomised self-checking bench for reg_alu_sequencer with a 32x64 register
// bank and a plain-arithmetic register model.
module tb_reg_alu_sequencer;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;
  logic [AW-1:0] rf_addr1, rf_addr2;
  logic [DW-1:0] rf_data1, rf_data2;
  logic          rf_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          done;
  logic [DW-1:0] result;
  logic [15:0]   op_count;

  reg_alu_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .result(result), .op_count(op_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- register bank (environment) ----------------
  logic [DW-1:0] bank [32];
  assign rf_data1 = bank[rf_addr1];
  assign rf_data2 = bank[rf_addr2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= DW'(i);
    end else if (rf_write) begin
      bank[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0]      ref_regs [32];
  logic [15:0]        exp_count;
  logic [DW-1:0]      exp_result;
  logic [AW+DW-1:0]   exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [1:0] opc, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (opc)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = DW'(i);
    exp_count  = 16'd0;
    exp_result = '0;
  endtask

  // Commits one operation to the model and queues its expected write-back.
  task automatic model_issue(input logic [1:0] opc, input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] d);
    logic [DW-1:0] v;
    v = alu_ref(opc, ref_regs[a], ref_regs[b]);
    ref_regs[d] = v;
    exp_result  = v;
    exp_q.push_back({d, v});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rf_write) begin
      check("done_with_write", {63'd0, done}, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, rf_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wb_addr", {59'd0, rf_waddr}, {59'd0, e[AW+DW-1:DW]});
        check("wb_data", rf_wdata, e[DW-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_junk();
    op_valid = 1'($urandom_range(0, 1));
    opcode   = 2'($urandom_range(0, 3));
    rs1      = AW'($urandom_range(0, 31));
    rs2      = AW'($urandom_range(0, 31));
    rd       = AW'($urandom_range(0, 31));
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge back in IDLE.
  task automatic run_op(input logic [1:0] opc, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d);
    check("ready_idle", {63'd0, op_ready}, 64'd1);
    op_valid = 1'b1; opcode = opc; rs1 = a; rs2 = b; rd = d;
    @(posedge clk);
    model_issue(opc, a, b, d);
    @(negedge clk);
    drive_junk();
    check("ready_read", {63'd0, op_ready}, 64'd0);
    check("addr1_read", {59'd0, rf_addr1}, {59'd0, a});
    check("addr2_read", {59'd0, rf_addr2}, {59'd0, b});
    check("write_read", {63'd0, rf_write}, 64'd0);
    @(negedge clk);
    drive_junk();
    check("ready_exec", {63'd0, op_ready}, 64'd0);
    check("write_exec", {63'd0, rf_write}, 64'd0);
    check("done_exec", {63'd0, done}, 64'd0);
    @(negedge clk);
    drive_junk();
    check("write_wb", {63'd0, rf_write}, 64'd1);
    check("done_wb", {63'd0, done}, 64'd1);
    check("ready_wb", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    exp_count = exp_count + 16'd1;
    check("op_count", {48'd0, op_count}, {48'd0, exp_count});
    check("result", result, exp_result);
    check("done_idle", {63'd0, done}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    rst = 1'b1; op_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, op_ready}, 64'd0);
    check("rst_count", {48'd0, op_count}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_write", {63'd0, rf_write}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_addr1", {59'd0, rf_addr1}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset during EXEC aborts the operation.
    op_valid = 1'b1; opcode = 2'd0; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd9;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", {63'd0, op_ready}, 64'd0);
    check("abort_write", {63'd0, rf_write}, 64'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_ready_after", {63'd0, op_ready}, 64'd1);
    check("abort_count", {48'd0, op_count}, 64'd0);
    check("abort_bank9", bank[9], 64'd9);

    // Directed scenarios.
    run_op(2'd0, 5'd3, 5'd4, 5'd5);
    run_op(2'd1, 5'd2, 5'd3, 5'd6);
    run_op(2'd0, 5'd1, 5'd1, 5'd7);
    run_op(2'd3, 5'd7, 5'd8, 5'd8);
    check("b2b_r8", ref_regs[8], 64'h0A);
    run_op(2'd2, 5'd12, 5'd10, 5'd12);
    check("and_r12", ref_regs[12], 64'd8);

    // op_valid held for 10 cycles: accepts at cycles 0, 4, 8 only.
    accepts = 0;
    op_valid = 1'b1; opcode = 2'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd20;
    for (int i = 0; i < 10; i++) begin
      check("held_ready", {63'd0, op_ready}, {63'd0, (i % 4) == 0});
      if ((i % 4) == 0) begin
        accepts++;
        model_issue(2'd0, 5'd1, 5'd2, 5'd20);
        exp_count = exp_count + 16'd1;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("held_accepts", 64'(accepts), 64'd3);
    check("held_count", {48'd0, op_count}, {48'd0, exp_count});

    // Random operations.
    for (int n = 0; n < 60; n++) begin
      run_op(2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
             AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end

    // Counter wrap, preloaded close to the top.
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFE;
    run_op(2'd0, 5'd1, 5'd2, 5'd21);
    run_op(2'd1, 5'd21, 5'd3, 5'd22);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 32; i++) check("bank_final", bank[i], ref_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
